// File: rtl/pi_digit_sequencer_if.sv
// pi_digit_sequencer_if: pacing, index-load, ROM and display signals of the digit sequencer
// master: the sequencer (drives rom_addr and display status); slave: pins, ROM and decoder side
interface pi_digit_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int LOAD_W = 5,
  parameter int DIV_W = 4
);
  logic run;
  logic step;
  logic [DIV_W-1:0] rate;
  logic load;
  logic [LOAD_W-1:0] load_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] digit;
  logic digit_valid;
  logic blank;
  logic busy;
  logic wrap;
  modport master(
    input run, step, rate, load, load_data, rom_data,
    output rom_addr, digit, digit_valid, blank, busy, wrap
  );
  modport slave(
    output run, step, rate, load, load_data, rom_data,
    input rom_addr, digit, digit_valid, blank, busy, wrap
  );
endinterface

// File: rtl/pi_digit_sequencer.sv
// pi_digit_sequencer: paces digit-ROM fetches and presents digit/valid/blank to the 7-seg decoder
// clk, reset (sync, active-high); bus.master: run/step/rate pacing, load/load_data index chunks,
// rom_addr/rom_data registered ROM access, digit/digit_valid/blank/busy/wrap display status
module pi_digit_sequencer #(
  parameter int ADDR_W = 10,
  parameter int LOAD_W = 5,
  parameter int DIV_W = 4,
  parameter int GAP_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  pi_digit_sequencer_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, CAPTURE = 3'd2, GAP = 3'd3, SHOW = 3'd4;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  logic [2:0] state;
  logic [ADDR_W-1:0] index;
  logic [3:0] digit;
  logic digit_valid, blank, wrap, step_q;
  logic [DIV_W-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic pacing, trigger, rep;
  always_comb begin
    pacing = state == IDLE || state == SHOW;
    trigger = (bus.step && !step_q) || (pacing && bus.run && cnt == bus.rate);
    rep = digit_valid && bus.rom_data == digit;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      index <= '0;
      digit <= '0;
      digit_valid <= 1'b0;
      blank <= 1'b1;
      wrap <= 1'b0;
      step_q <= 1'b0;
      cnt <= '0;
      gap_cnt <= '0;
    end else begin
      step_q <= bus.step;
      wrap <= 1'b0;
      cnt <= (pacing && bus.run && cnt != bus.rate) ? cnt + 1'b1 : '0;
      if (bus.load) begin
        // chunks shift in from the top, so the first of two loads ends up in the low bits
        index <= {bus.load_data, index[ADDR_W-1:LOAD_W]};
        state <= IDLE;
        digit <= '0;
        digit_valid <= 1'b0;
        blank <= 1'b1;
        cnt <= '0;
      end else
        case (state)
          IDLE, SHOW: state <= trigger ? FETCH : state;
          FETCH: state <= CAPTURE;
          CAPTURE: begin
            digit <= bus.rom_data;
            digit_valid <= 1'b1;
            index <= index + 1'b1;
            wrap <= &index;
            // a repeated digit blanks first so the decoder shows a visible gap
            state <= rep ? GAP : SHOW;
            blank <= rep;
            gap_cnt <= GW'(GAP_CYCLES - 1);
          end
          GAP: begin
            gap_cnt <= gap_cnt - 1'b1;
            state <= gap_cnt == '0 ? SHOW : GAP;
            blank <= gap_cnt != '0;
          end
          default: state <= IDLE;
        endcase
    end
  assign bus.rom_addr = index;
  assign bus.digit = digit;
  assign bus.digit_valid = digit_valid;
  assign bus.blank = blank;
  assign bus.wrap = wrap;
  assign bus.busy = state == FETCH || state == CAPTURE || state == GAP;
endmodule

// File: tb/tb_pi_digit_sequencer.sv
// tb_pi_digit_sequencer: directed vector table plus hand sequences for run, repeat gap and reset
module tb_pi_digit_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pi_digit_sequencer_if #(.ADDR_W(10), .LOAD_W(5), .DIV_W(4)) bus();
  pi_digit_sequencer #(.ADDR_W(10), .LOAD_W(5), .DIV_W(4), .GAP_CYCLES(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  logic [3:0] rom [1024];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic step;
    logic load;
    logic [4:0] ld;
    logic [9:0] addr;
    logic [3:0] dig;
    logic v;
    logic b;
    logic bz;
    logic w;
  } vec_t;
  vec_t tbl[16];
  logic [3:0] run_seq[5];
  logic [3:0] prev;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic logic [17:0] outs();
    return {bus.rom_addr, bus.digit, bus.digit_valid, bus.blank, bus.busy, bus.wrap};
  endfunction
  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 4'(i % 10);
    rom[0] = 4'd3;
    rom[1] = 4'd1;
    rom[2] = 4'd4;
    rom[3] = 4'd1;
    rom[4] = 4'd5;
    rom[5] = 4'd9;
    rom[6] = 4'd9;
    rom[1023] = 4'd7;
    run_seq[0] = 4'd3;
    run_seq[1] = 4'd1;
    run_seq[2] = 4'd4;
    run_seq[3] = 4'd1;
    run_seq[4] = 4'd5;
    tbl[0]  = '{1'b1, 1'b0, 5'd0,  10'd0,    4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 5'd0,  10'd0,    4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 5'd0,  10'd1,    4'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 5'd0,  10'd1,    4'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 5'd0,  10'd1,    4'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 5'd1,  10'd32,   4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 5'd2,  10'd65,   4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 5'd0,  10'd65,   4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 5'd0,  10'd2,    4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 5'd0,  10'd2,    4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 5'd31, 10'd992,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 5'd31, 10'd1023, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 5'd0,  10'd1023, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 5'd0,  10'd1023, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 5'd0,  10'd0,    4'd7, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 5'd0,  10'd0,    4'd7, 1'b1, 1'b0, 1'b0, 1'b0};
    bus.run = 1'b0;
    bus.step = 1'b0;
    bus.rate = 4'd0;
    bus.load = 1'b0;
    bus.load_data = 5'd0;
    tick(2);
    chk("reset", 32'(outs()), 32'({10'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.step = tbl[i].step;
      bus.load = tbl[i].load;
      bus.load_data = tbl[i].ld;
      tick(1);
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({tbl[i].addr, tbl[i].dig, tbl[i].v, tbl[i].b, tbl[i].bz, tbl[i].w}));
    end
    bus.step = 1'b0;
    bus.load = 1'b0;
    bus.rate = 4'd3;
    bus.run = 1'b1;
    prev = 4'd7;
    for (int k = 0; k < 5; k++) begin
      tick(3);
      chk($sformatf("run%0d_wait", k), 32'({bus.busy, bus.digit}), 32'({1'b0, prev}));
      if (k == 2) bus.step = 1'b1;
      tick(1);
      bus.step = 1'b0;
      chk($sformatf("run%0d_fetch", k), 32'(bus.busy), 32'(1'b1));
      tick(1);
      chk($sformatf("run%0d_capture", k), 32'({bus.busy, bus.digit}), 32'({1'b1, prev}));
      tick(1);
      chk($sformatf("run%0d_show", k), 32'({bus.rom_addr, bus.digit, bus.blank, bus.busy}),
          32'({10'(k + 1), run_seq[k], 1'b0, 1'b0}));
      prev = run_seq[k];
    end
    bus.rate = 4'd0;
    tick(1);
    chk("gap_fetch1", 32'({bus.rom_addr, bus.busy}), 32'({10'd5, 1'b1}));
    tick(2);
    chk("gap_show1", 32'({bus.rom_addr, bus.digit, bus.blank, bus.busy}), 32'({10'd6, 4'd9, 1'b0, 1'b0}));
    tick(2);
    chk("gap_capture2", 32'({bus.rom_addr, bus.digit, bus.blank, bus.busy}), 32'({10'd6, 4'd9, 1'b0, 1'b1}));
    tick(1);
    chk("gap_blank1", 32'({bus.rom_addr, bus.digit, bus.blank, bus.busy}), 32'({10'd7, 4'd9, 1'b1, 1'b1}));
    tick(1);
    chk("gap_blank2", 32'({bus.rom_addr, bus.digit, bus.blank, bus.busy}), 32'({10'd7, 4'd9, 1'b1, 1'b1}));
    bus.run = 1'b0;
    tick(1);
    chk("gap_show2", 32'({bus.rom_addr, bus.digit, bus.blank, bus.busy}), 32'({10'd7, 4'd9, 1'b0, 1'b0}));
    tick(1);
    chk("gap_hold", 32'({bus.rom_addr, bus.digit, bus.blank, bus.busy}), 32'({10'd7, 4'd9, 1'b0, 1'b0}));
    bus.step = 1'b1;
    tick(1);
    chk("midreset_fetch", 32'(bus.busy), 32'(1'b1));
    reset = 1'b1;
    tick(1);
    chk("midreset", 32'(outs()), 32'({10'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
    bus.step = 1'b0;
    reset = 1'b0;
    tick(1);
    chk("after_reset", 32'(outs()), 32'({10'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pi_digit_sequencer.md
# pi_digit_sequencer

Sequencer for the registered 4-bit digit ROM that feeds the 7-segment decoder. It owns the ROM address (digit index) and paces digit advances from a programmable prescaler or a manual step input. It also supports jumping to an arbitrary start index by shifting in 5-bit chunks from the pins. It presents a stable digit with valid/blank qualifiers to the decoder, and blanks the display briefly between equal consecutive digits so repeats stay visible.

## Interface
Parameters:
- ADDR_W, 10, digit index / ROM address width
- LOAD_W, 5, chunk width of the index load path (ADDR_W >= LOAD_W)
- DIV_W, 4, prescaler rate width
- GAP_CYCLES, 2, blank cycles inserted before showing a digit equal to the previous one (>= 1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- run  in  1  level; enables prescaler-paced advance
- step  in  1  level; each rising edge requests one advance
- rate  in  DIV_W  prescaler terminal count
- load  in  1  per-cycle load strobe
- load_data  in  LOAD_W  index chunk
- rom_addr  out  ADDR_W  ROM address, equal to the index register
- rom_data  in  4  ROM output, valid one cycle after rom_addr is sampled
- digit  out  4  displayed digit code
- digit_valid  out  1  digit holds a fetched value
- blank  out  1  decoder must blank segments
- busy  out  1  state is FETCH, CAPTURE or GAP
- wrap  out  1  one-cycle pulse when the index wraps

## Operation
- States: IDLE, FETCH, CAPTURE, GAP, SHOW.
- Reset state and outputs:
  - state=IDLE, index=0, digit=0, digit_valid=0, blank=1, busy=0, wrap=0.
  - Prescaler count cnt=0; step edge register step_q=0.
- Trigger:
  - Step trigger: step & ~step_q, with step_q registered every cycle.
  - Prescaler trigger: run & (cnt==rate), counted only in IDLE/SHOW.
  - trigger = step trigger OR prescaler trigger. Simultaneous sources produce a single advance.
- Prescaler:
  - In IDLE/SHOW with run=1: cnt increments; on cnt==rate, cnt<=0.
  - run=0 forces cnt<=0.
  - In FETCH/CAPTURE/GAP cnt holds at 0.
  - rate=0 triggers on every eligible cycle.
- Transitions:
  - IDLE/SHOW, trigger → FETCH.
  - FETCH → CAPTURE (ROM samples rom_addr).
  - CAPTURE:
    - digit<=rom_data, digit_valid<=1.
    - index<=index+1, modulo 2^ADDR_W. wrap<=1 if index was all-ones.
    - If digit_valid was already 1 and rom_data==old digit → GAP; else → SHOW.
  - GAP lasts exactly GAP_CYCLES cycles, then → SHOW.
- Triggers arriving in FETCH/CAPTURE/GAP are dropped, not queued.
- Load (any state, priority over trigger and the transitions above):
  - index <= {load_data, index[ADDR_W-1:LOAD_W]}.
  - state<=IDLE, digit<=0, digit_valid<=0, cnt<=0.
  - An in-flight fetch is aborted: no index increment, no wrap.
  - Two consecutive loads set a full 10-bit index. The first chunk lands in the low bits.
- Outputs:
  - blank=1 in IDLE, GAP, and in any state while digit_valid=0; blank=0 in SHOW.
  - In FETCH/CAPTURE, blank and digit keep their previous values.
  - wrap is registered, high for the single cycle after CAPTURE.

## Timing
- Trigger sampled in cycle n:
  - FETCH in n+1.
  - CAPTURE in n+2.
  - New digit and SHOW visible in n+3, or GAP in n+3..n+2+GAP_CYCLES then SHOW.
- rom_addr is stable throughout FETCH. It changes only at the end of CAPTURE or on load.
- Continuous run, no repeats: advance period = rate+3 cycles. With a repeat: rate+3+GAP_CYCLES.
- Reset asserted mid-operation: all reset values on the next edge; no partial capture.

## Test plan
- Reset: hold reset 2 cycles → rom_addr=0, digit=0, digit_valid=0, blank=1, busy=0, wrap=0.
- Single step, ROM model addr0=3: step rises in cycle n → FETCH n+1, CAPTURE n+2, digit=3, digit_valid=1, blank=0, rom_addr=1 in n+3; holding step high gives no second advance.
- Run, rate=3, ROM 3,1,4,1,5: digit changes every 6 cycles in ROM order. step pulsed on the same cycle as a prescaler trigger → one advance only.
- Repeat gap, ROM addr5=addr6=9, rate=0, GAP_CYCLES=2: after digit 9 shows, the next advance gives blank=1 for exactly 2 cycles with digit=9, then blank=0.
- Load: load pulses with load_data=5'b00001 then 5'b00010 → rom_addr=65, digit_valid=0; a load during FETCH aborts the fetch and rom_addr reflects the load only.
- Wrap: two loads of 5'b11111 (index 1023), then step → digit=ROM[1023], rom_addr=0, wrap high exactly one cycle.
